// File: rtl/mult_div_unit_pkg.sv
// Shared MD operation codes and latencies for the execute-stage
// multiply/divide unit, its controller and the hazard unit.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_e;

    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] MULT_CYCLES = 4'd5;
    localparam logic [CNT_W-1:0] DIV_CYCLES  = 4'd10;

endpackage

// File: rtl/mult_div_unit.sv
// Execute-stage HI/LO unit: fixed-latency MULT/DIV with a countdown,
// results computed from latched operands and committed at count end.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic        E_Start,
    input  logic [31:0] E_V1,
    input  logic [31:0] E_V2,
    output logic        E_Busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [3:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             busy_q;

    logic             is_md;
    logic             start_ok;
    logic             done;

    always_comb begin
        is_md = 1'b0;
        case (E_MDOp)
            MD_MULT, MD_MULTU,
            MD_DIV, MD_DIVU: is_md = 1'b1;
            default:         is_md = 1'b0;
        endcase
    end

    assign start_ok = E_Start && is_md && !busy_q;
    assign done     = (cnt == 4'd1);

    always_comb begin
        cnt_n = cnt;
        if (start_ok) begin
            if (E_MDOp == MD_MULT || E_MDOp == MD_MULTU)
                cnt_n = MULT_CYCLES;
            else
                cnt_n = DIV_CYCLES;
        end else if (cnt != '0) begin
            cnt_n = cnt - 4'd1;
        end
    end

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide on magnitudes so INT_MIN / -1 wraps cleanly.
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] ds_mag;
    logic [31:0] ds_u;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    assign b_zero = (b_q == '0);
    assign a_mag  = a_q[31] ? -a_q : a_q;
    assign b_mag  = b_q[31] ? -b_q : b_q;
    assign ds_mag = b_zero ? 32'd1 : b_mag;
    assign ds_u   = b_zero ? 32'd1 : b_q;
    assign q_mag  = a_mag / ds_mag;
    assign r_mag  = a_mag % ds_mag;
    assign q_s    = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
    assign r_s    = a_q[31] ? -r_mag : r_mag;
    assign q_u    = a_q / ds_u;
    assign r_u    = a_q % ds_u;

    logic        res_we;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        res_we = 1'b0;
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            MD_MULT: begin
                res_we = 1'b1;
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_we = 1'b1;
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_we = !b_zero;
                res_hi = r_s;
                res_lo = q_s;
            end
            MD_DIVU: begin
                res_we = !b_zero;
                res_hi = r_u;
                res_lo = q_u;
            end
            default: res_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt    <= cnt_n;
            busy_q <= (cnt_n != '0);
            if (start_ok) begin
                op_q <= E_MDOp;
                a_q  <= E_V1;
                b_q  <= E_V2;
            end
            if (done && res_we) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
            if (!busy_q && E_MDOp == MD_MTHI)
                hi_q <= E_V1;
            if (!busy_q && E_MDOp == MD_MTLO)
                lo_q <= E_V1;
        end
    end

    assign E_Busy = busy_q;
    assign E_HI   = hi_q;
    assign E_LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port E_MDOp  input  4  operation code: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; codes 7-15 are treated as NONE.
REQ-004 SHALL have port E_Start  input  1  one-cycle pulse qualifying E_MDOp for MULT/MULTU/DIV/DIVU.
REQ-005 SHALL have port E_V1  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
REQ-006 SHALL have port E_V2  input  32  rt operand (divisor / multiplier).
REQ-007 SHALL have port E_Busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port E_HI  output  32  architectural HI register.
REQ-009 SHALL have port E_LO  output  32  architectural LO register.

Function
REQ-010 SHALL sample E_Start, E_MDOp, E_V1 and E_V2 on a rising edge only when E_Busy=0 and reset=0.
REQ-011 SHALL, on an accepted start with MULT/MULTU, load a cycle counter with 5; with DIV/DIVU, load it with 10.
REQ-012 SHALL drive E_Busy = (counter != 0), registered, so that E_Busy rises on the edge that accepts the start.
REQ-013 SHALL decrement the counter by 1 on each edge while it is nonzero.
REQ-014 SHALL write HI/LO on the edge where the counter goes 1->0; E_Busy falls on that same edge.
REQ-015 SHALL give an operation started at edge t: MULT E_Busy high for edges t..t+4 (5 cycles), DIV E_Busy high for 10 cycles, result visible after edge t+5 / t+10.
REQ-016 SHALL latch operands and operation at the start edge and ignore later changes of E_V1/E_V2/E_MDOp.
REQ-017 SHALL compute MULT as a signed 32x32->64 product: HI=[63:32], LO=[31:0]; MULTU as the unsigned product.
REQ-018 SHALL compute DIV as signed division: LO=quotient truncated toward zero, HI=remainder with the dividend's sign; DIVU as the unsigned quotient/remainder.
REQ-019 SHALL, for DIV/DIVU with divisor 0, still run 10 busy cycles and leave HI/LO unchanged.
REQ-020 SHALL, for DIV of 0x80000000 by 0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-021 SHALL write HI (MTHI) or LO (MTLO) from E_V1 on the same edge when E_Busy=0, independent of E_Start, with no busy cycles.
REQ-022 SHALL ignore E_Start and MTHI/MTLO while E_Busy=1; the hazard unit guarantees these are not issued then.
REQ-023 SHALL treat E_Start=1 with E_MDOp in {NONE, MTHI, MTLO, 7-15} as no start.
REQ-024 SHALL present E_HI/E_LO directly from registers (MFHI/MFLO read them combinationally in E); the hazard unit stalls D-stage MD instructions while (E_Start | E_Busy).

Reset
REQ-025 SHALL, on reset=1 at a rising edge, clear the counter, E_Busy, E_HI and E_LO to 0, aborting any in-flight operation.
REQ-026 SHALL give reset priority over a simultaneous E_Start or MTHI/MTLO, so no write occurs on that edge.
REQ-027 SHALL initialise all registers to 0 at time zero for simulation.

Structure
REQ-028 SHALL place the MDOp codes and the latencies (MULT_CYCLES=5, DIV_CYCLES=10) in constants.v, shared with the controller and hazard unit.
REQ-029 SHALL be a single module: latency counter plus result registers; the product and quotient are computed combinationally from latched operands and committed at count end. There are no sub-modules.

Verification
REQ-030 SHALL cover MULT with E_V1=0xFFFFFFFE (-2) and E_V2=3 -> E_Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 SHALL cover MULTU with E_V1=0xFFFFFFFF and E_V2=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 SHALL cover DIV with E_V1=-7 and E_V2=2 -> E_Busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with 7 and 0 -> HI/LO unchanged after 10 cycles.
REQ-033 SHALL cover MTHI with E_V1=0x12345678 while idle -> E_HI=0x12345678 the next cycle and E_Busy stays 0; MTLO issued while busy -> LO unchanged.
REQ-034 SHALL cover reset asserted at busy cycle 4 of a DIV -> next cycle E_Busy=0, HI=LO=0, and no later write.
REQ-035 SHALL cover E_Start pulsed again with changed operands during a MULT -> result reflects the first operands only and E_Busy falls after the fifth cycle.
